// File: rtl/filter_rule_commit_ctrl_pkg.sv
// Shared types for the filter rule commit controller: rule layout, AXIS widths, FSM states.
package filter_rule_commit_ctrl_pkg;

  localparam int NUM_RULES = 2;
  localparam int DATA_W    = 512;
  localparam int KEEP_W    = 64;
  localparam int USER_W    = 48;
  localparam int WAIT_W    = 16;

  typedef struct packed {
    logic [31:0]  ipv4_addr;
    logic [127:0] ipv6_addr;
    logic [31:0]  port;
  } filter_rule_t;

  typedef filter_rule_t [NUM_RULES-1:0] rule_set_t;

  typedef enum logic {
    IDLE,
    WAIT_EOP
  } commit_state_e;

endpackage

// File: rtl/filter_rule_commit_ctrl_if.sv
// AXI-Stream beat bundle between the RX adapter, the commit gate and the filter pipeline.
interface filter_rule_commit_ctrl_if;
  import filter_rule_commit_ctrl_pkg::*;

  logic              tvalid;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic [USER_W-1:0] tuser;
  logic              tready;

  modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);

endinterface

// File: rtl/filter_rule_commit_ctrl.sv
// Inline AXIS gate owning the active filter rules; host commits swap in only at a packet
// boundary, with a single-cycle first-beat hold so back-to-back traffic still yields a window.
module filter_rule_commit_ctrl
  import filter_rule_commit_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int EPOCH_W        = 8
) (
  input  logic                        aclk,
  input  logic                        areset,
  filter_rule_commit_ctrl_if.slave    s_axis,
  filter_rule_commit_ctrl_if.master   m_axis,
  input  rule_set_t                   shadow_rules,
  input  logic                        commit_req,
  output rule_set_t                   active_rules,
  output logic                        commit_ack,
  output logic                        commit_err,
  output logic                        commit_busy,
  output logic [EPOCH_W-1:0]          rules_epoch
);

  localparam bit                TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [WAIT_W-1:0] TO_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  commit_state_e     r_state;
  commit_state_e     w_state_nxt;
  rule_set_t         r_pending;
  rule_set_t         r_active;
  logic [EPOCH_W-1:0] r_epoch;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_in_pkt;
  logic              r_ack;
  logic              r_err;

  logic w_hold;
  logic w_m_vld;
  logic w_beat;
  logic w_latch;
  logic w_apply;
  logic w_timeout;

  // Hold is only possible outside a packet, so it can only ever delay a first beat.
  assign w_hold  = (r_state == WAIT_EOP) && !r_in_pkt;
  assign w_m_vld = s_axis.tvalid && !w_hold;
  assign w_beat  = w_m_vld && m_axis.tready;

  assign m_axis.tvalid = w_m_vld;
  assign m_axis.tdata  = s_axis.tdata;
  assign m_axis.tkeep  = s_axis.tkeep;
  assign m_axis.tlast  = s_axis.tlast;
  assign m_axis.tuser  = s_axis.tuser;
  assign s_axis.tready = m_axis.tready && !w_hold;

  assign active_rules = r_active;
  assign commit_ack   = r_ack;
  assign commit_err   = r_err;
  assign commit_busy  = (r_state == WAIT_EOP);
  assign rules_epoch  = r_epoch;

  always_ff @(posedge aclk) begin
    if (areset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_apply     = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        // A request landing on the ack/err pulse cycle is dropped; the host polls busy.
        if (commit_req && !r_ack && !r_err) begin
          w_latch     = 1'b1;
          w_state_nxt = WAIT_EOP;
        end
      end
      WAIT_EOP: begin
        if (!r_in_pkt) begin
          w_apply     = 1'b1;
          w_state_nxt = IDLE;
        end else if (TO_EN && (r_wait_cnt == TO_LAST)) begin
          w_timeout   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_pending  <= '0;
      r_active   <= '0;
      r_epoch    <= '0;
      r_wait_cnt <= '0;
      r_in_pkt   <= 1'b0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_ack <= w_apply;
      r_err <= w_timeout;
      if (w_beat) r_in_pkt <= !s_axis.tlast;
      if (w_latch) begin
        r_pending  <= shadow_rules;
        r_wait_cnt <= '0;
      end else if ((r_state == WAIT_EOP) && !w_apply && !w_timeout && (r_wait_cnt != '1)) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_apply) begin
        r_active <= r_pending;
        r_epoch  <= r_epoch + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_filter_rule_commit_ctrl.sv
// Directed bench for filter_rule_commit_ctrl with a 16-cycle boundary timeout.
module tb_filter_rule_commit_ctrl;
  import filter_rule_commit_ctrl_pkg::*;

  logic       aclk;
  logic       areset;
  rule_set_t  shadow_rules;
  logic       commit_req;
  rule_set_t  active_rules;
  logic       commit_ack;
  logic       commit_err;
  logic       commit_busy;
  logic [7:0] rules_epoch;

  int checks;
  int failures;

  filter_rule_commit_ctrl_if s_if ();
  filter_rule_commit_ctrl_if m_if ();

  filter_rule_commit_ctrl #(
    .TIMEOUT_CYCLES (16),
    .EPOCH_W        (8)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .s_axis       (s_if.slave),
    .m_axis       (m_if.master),
    .shadow_rules (shadow_rules),
    .commit_req   (commit_req),
    .active_rules (active_rules),
    .commit_ack   (commit_ack),
    .commit_err   (commit_err),
    .commit_busy  (commit_busy),
    .rules_epoch  (rules_epoch)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  function automatic rule_set_t mk_rules(input logic [31:0] v4, input logic [31:0] port);
    rule_set_t r;
    r = '0;
    r[0].ipv4_addr = v4;
    r[0].port      = port;
    r[1].ipv6_addr = {96'h0, v4};
    return r;
  endfunction

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive_beat(input logic vld, input logic last, input logic [31:0] dat);
    s_if.tvalid = vld;
    s_if.tlast  = last;
    s_if.tdata  = {480'h0, dat};
    s_if.tkeep  = '1;
    s_if.tuser  = {16'h0, dat};
  endtask

  task automatic test_reset();
    areset = 1'b1;
    step();
    step();
    areset = 1'b0;
    #1;
    checks++;
    if (active_rules !== '0) begin failures++; $display("FAIL reset_active got=%h exp=0", active_rules); end
    checks++;
    if (rules_epoch !== 8'd0) begin failures++; $display("FAIL reset_epoch got=%0d exp=0", rules_epoch); end
    checks++;
    if ({commit_ack, commit_err, commit_busy} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {commit_ack, commit_err, commit_busy});
    end
    checks++;
    if (s_if.tready !== 1'b1) begin failures++; $display("FAIL reset_tready got=%b exp=1", s_if.tready); end
  endtask

  task automatic test_idle_commit();
    rule_set_t exp;
    exp = mk_rules(32'h0A000001, 32'd80);
    shadow_rules = exp;
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    #1;
    checks++;
    if ({commit_busy, s_if.tready, commit_ack} !== 3'b100) begin
      failures++; $display("FAIL idle_hold busy/tready/ack got=%b exp=100", {commit_busy, s_if.tready, commit_ack});
    end
    checks++;
    if (active_rules !== '0) begin failures++; $display("FAIL idle_early_swap got=%h exp=0", active_rules); end
    step();
    checks++;
    if ({commit_ack, commit_busy, s_if.tready} !== 3'b101) begin
      failures++; $display("FAIL idle_ack ack/busy/tready got=%b exp=101", {commit_ack, commit_busy, s_if.tready});
    end
    checks++;
    if (active_rules !== exp) begin failures++; $display("FAIL idle_active got=%h exp=%h", active_rules, exp); end
    checks++;
    if (rules_epoch !== 8'd1) begin failures++; $display("FAIL idle_epoch got=%0d exp=1", rules_epoch); end
    // request on the ack cycle must not start a new commit
    shadow_rules = mk_rules(32'hDEADBEEF, 32'd1);
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    #1;
    checks++;
    if ({commit_busy, commit_ack} !== 2'b00) begin
      failures++; $display("FAIL ack_cycle_req busy/ack got=%b exp=00", {commit_busy, commit_ack});
    end
    step();
  endtask

  task automatic test_mid_packet();
    rule_set_t old_r, exp;
    old_r = mk_rules(32'h0A000001, 32'd80);
    exp   = mk_rules(32'hC0A80101, 32'd443);
    shadow_rules = exp;
    drive_beat(1'b1, 1'b0, 32'd1);
    #1;
    checks++;
    if (s_if.tready !== 1'b1) begin failures++; $display("FAIL mid_beat1_tready got=%b exp=1", s_if.tready); end
    step();
    drive_beat(1'b1, 1'b0, 32'd2);
    commit_req = 1'b1;
    #1;
    checks++;
    if (s_if.tready !== 1'b1) begin failures++; $display("FAIL mid_beat2_tready got=%b exp=1", s_if.tready); end
    step();
    commit_req = 1'b0;
    drive_beat(1'b1, 1'b0, 32'd3);
    #1;
    checks++;
    if ({commit_busy, s_if.tready, m_if.tvalid} !== 3'b111) begin
      failures++; $display("FAIL mid_beat3 busy/tready/mvld got=%b exp=111", {commit_busy, s_if.tready, m_if.tvalid});
    end
    checks++;
    if (m_if.tdata[31:0] !== 32'd3 || m_if.tuser[31:0] !== 32'd3) begin
      failures++; $display("FAIL mid_passthru data=%0d user=%0d exp=3", m_if.tdata[31:0], m_if.tuser[31:0]);
    end
    step();
    drive_beat(1'b1, 1'b1, 32'd4);
    #1;
    checks++;
    if ({s_if.tready, m_if.tlast} !== 2'b11) begin
      failures++; $display("FAIL mid_beat4 tready/tlast got=%b exp=11", {s_if.tready, m_if.tlast});
    end
    step();
    drive_beat(1'b0, 1'b0, 32'd0);
    #1;
    checks++;
    if ({s_if.tready, commit_ack, commit_busy} !== 3'b001) begin
      failures++; $display("FAIL mid_hold tready/ack/busy got=%b exp=001", {s_if.tready, commit_ack, commit_busy});
    end
    checks++;
    if (active_rules !== old_r) begin failures++; $display("FAIL mid_early_swap got=%h exp=%h", active_rules, old_r); end
    step();
    checks++;
    if ({commit_ack, rules_epoch} !== {1'b1, 8'd2}) begin
      failures++; $display("FAIL mid_ack ack=%b epoch=%0d exp ack=1 epoch=2", commit_ack, rules_epoch);
    end
    checks++;
    if (active_rules !== exp) begin failures++; $display("FAIL mid_active got=%h exp=%h", active_rules, exp); end
    step();
  endtask

  task automatic test_back_to_back();
    rule_set_t exp;
    int src, exp_out, stalls, acks;
    exp = mk_rules(32'h08080808, 32'd53);
    shadow_rules = exp;
    src = 100; exp_out = 100; stalls = 0; acks = 0;
    for (int i = 0; i < 12; i++) begin
      drive_beat(1'b1, 1'b1, src[31:0]);
      commit_req = (i == 3);
      #1;
      if (s_if.tready !== 1'b1) stalls++;
      if (commit_ack === 1'b1) acks++;
      if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
        checks++;
        if (m_if.tdata[31:0] !== exp_out[31:0]) begin
          failures++; $display("FAIL b2b_beat got=%0d exp=%0d", m_if.tdata[31:0], exp_out);
        end
        exp_out++;
      end
      if (s_if.tready === 1'b1) src++;
      step();
    end
    commit_req = 1'b0;
    drive_beat(1'b0, 1'b0, 32'd0);
    checks++;
    if (stalls !== 1) begin failures++; $display("FAIL b2b_stalls got=%0d exp=1", stalls); end
    checks++;
    if (exp_out !== src || src !== 111) begin
      failures++; $display("FAIL b2b_count out=%0d src=%0d exp=111", exp_out, src);
    end
    checks++;
    if (acks !== 1) begin failures++; $display("FAIL b2b_acks got=%0d exp=1", acks); end
    checks++;
    if (active_rules !== exp || rules_epoch !== 8'd3) begin
      failures++; $display("FAIL b2b_active epoch=%0d exp=3 rules=%h exp=%h", rules_epoch, active_rules, exp);
    end
  endtask

  task automatic test_timeout();
    rule_set_t keep_r;
    int n_busy;
    keep_r = mk_rules(32'h08080808, 32'd53);
    shadow_rules = mk_rules(32'h11111111, 32'd22);
    drive_beat(1'b1, 1'b0, 32'd7);
    step();
    drive_beat(1'b0, 1'b0, 32'd0);
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    n_busy = 0;
    for (int i = 0; i < 40; i++) begin
      if (commit_busy !== 1'b1) break;
      n_busy++;
      step();
    end
    checks++;
    if (n_busy !== 16) begin failures++; $display("FAIL to_busy_cycles got=%0d exp=16", n_busy); end
    checks++;
    if ({commit_err, commit_ack} !== 2'b10) begin
      failures++; $display("FAIL to_err err/ack got=%b exp=10", {commit_err, commit_ack});
    end
    checks++;
    if (active_rules !== keep_r || rules_epoch !== 8'd3) begin
      failures++; $display("FAIL to_unchanged epoch=%0d exp=3 rules=%h", rules_epoch, active_rules);
    end
    step();
    checks++;
    if (commit_err !== 1'b0) begin failures++; $display("FAIL to_err_pulse got=%b exp=0", commit_err); end
    drive_beat(1'b1, 1'b1, 32'd8);
    step();
    drive_beat(1'b0, 1'b0, 32'd0);
    step();
  endtask

  task automatic test_busy_ignore();
    rule_set_t first_r;
    first_r = mk_rules(32'hAAAA0001, 32'd1000);
    drive_beat(1'b1, 1'b0, 32'd1);
    step();
    drive_beat(1'b0, 1'b0, 32'd0);
    shadow_rules = first_r;
    commit_req = 1'b1;
    step();
    shadow_rules = mk_rules(32'hBBBB0002, 32'd2000);
    step();
    commit_req = 1'b0;
    step();
    drive_beat(1'b1, 1'b1, 32'd2);
    step();
    drive_beat(1'b0, 1'b0, 32'd0);
    #1;
    checks++;
    if ({s_if.tready, commit_busy} !== 2'b01) begin
      failures++; $display("FAIL busy_hold tready/busy got=%b exp=01", {s_if.tready, commit_busy});
    end
    step();
    checks++;
    if (commit_ack !== 1'b1 || active_rules !== first_r || rules_epoch !== 8'd4) begin
      failures++; $display("FAIL busy_first ack=%b epoch=%0d exp 1/4 rules=%h exp=%h",
                           commit_ack, rules_epoch, active_rules, first_r);
    end
    step();
    step();
    checks++;
    if ({commit_busy, commit_ack} !== 2'b00 || active_rules !== first_r) begin
      failures++; $display("FAIL busy_second busy/ack got=%b rules=%h", {commit_busy, commit_ack}, active_rules);
    end
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    drive_beat(1'b1, 1'b0, 32'd5);
    step();
    drive_beat(1'b0, 1'b0, 32'd0);
    shadow_rules = mk_rules(32'hCCCC0003, 32'd3);
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    #1;
    checks++;
    if (commit_busy !== 1'b1) begin failures++; $display("FAIL rst_pre_busy got=%b exp=1", commit_busy); end
    areset = 1'b1;
    step();
    areset = 1'b0;
    #1;
    checks++;
    if ({commit_busy, commit_ack, commit_err} !== 3'b000 || active_rules !== '0 || rules_epoch !== 8'd0) begin
      failures++; $display("FAIL rst_mid flags=%b epoch=%0d rules=%h exp 000/0/0",
                           {commit_busy, commit_ack, commit_err}, rules_epoch, active_rules);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (commit_ack === 1'b1 || commit_err === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL rst_dropped pulses=%0d exp=0", seen); end
    // in_pkt must be cleared by reset, so a fresh commit holds immediately
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    #1;
    checks++;
    if (s_if.tready !== 1'b0) begin failures++; $display("FAIL rst_inpkt_clr tready=%b exp=0", s_if.tready); end
    step();
    checks++;
    if (commit_ack !== 1'b1 || rules_epoch !== 8'd1) begin
      failures++; $display("FAIL rst_recommit ack=%b epoch=%0d exp 1/1", commit_ack, rules_epoch);
    end
    step();
  endtask

  task automatic test_epoch_wrap();
    areset = 1'b1;
    step();
    areset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      shadow_rules = mk_rules(i[31:0], 32'd9);
      commit_req = 1'b1;
      step();
      commit_req = 1'b0;
      step();
      if (i == 254) begin
        checks++;
        if (rules_epoch !== 8'd255) begin failures++; $display("FAIL wrap_255 got=%0d exp=255", rules_epoch); end
      end
      step();
    end
    checks++;
    if (rules_epoch !== 8'd0) begin failures++; $display("FAIL wrap_zero got=%0d exp=0", rules_epoch); end
    checks++;
    if (active_rules !== mk_rules(32'd255, 32'd9)) begin
      failures++; $display("FAIL wrap_active got=%h", active_rules);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    areset = 1'b1;
    commit_req = 1'b0;
    shadow_rules = '0;
    m_if.tready = 1'b1;
    drive_beat(1'b0, 1'b0, 32'd0);
    test_reset();
    test_idle_commit();
    test_mid_packet();
    test_back_to_back();
    test_timeout();
    test_busy_ignore();
    test_reset_mid_wait();
    test_epoch_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
